// File: rtl/pipeline_ex_muldiv_if.sv
// EX-stage bundle: operand select/forwarding controls, ALU operands and the
// multiply/divide request, result and stall handshake.
interface pipeline_ex_muldiv_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int IMM_W   = 16
);
    logic [1:0]         fwd_a, fwd_b;
    logic               alu_src1, alu_src2, ext_op, lu_op;
    logic [SHAMT_W-1:0] shamt;
    logic [IMM_W-1:0]   imm;
    logic [WIDTH-1:0]   data_a, data_b, exmem_data, memwb_data;
    logic [WIDTH-1:0]   op_a, op_b;
    logic               md_valid;
    logic [2:0]         md_op;
    logic [WIDTH-1:0]   md_result;
    logic               md_busy, md_done, stall;
    logic [WIDTH-1:0]   hi, lo;

    modport slave (
        input  fwd_a, fwd_b, alu_src1, alu_src2, ext_op, lu_op, shamt, imm,
               data_a, data_b, exmem_data, memwb_data, md_valid, md_op,
        output op_a, op_b, md_result, md_busy, md_done, stall, hi, lo
    );

    modport master (
        output fwd_a, fwd_b, alu_src1, alu_src2, ext_op, lu_op, shamt, imm,
               data_a, data_b, exmem_data, memwb_data, md_valid, md_op,
        input  op_a, op_b, md_result, md_busy, md_done, stall, hi, lo
    );
endinterface

// File: rtl/pipeline_ex_muldiv.sv
// EX stage: operand selection/extension/forwarding plus an iterative
// shift-add multiplier / restoring divider owning the HI/LO registers.
module pipeline_ex_muldiv #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int IMM_W   = 16
) (
    input logic                clk,
    input logic                reset,
    pipeline_ex_muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    function automatic logic [WIDTH-1:0] fwd_sel(input logic [1:0] sel,
                                                 input logic [WIDTH-1:0] src, memwb, exmem);
        case (sel)
            2'b00:   return src;
            2'b01:   return memwb;
            2'b10:   return exmem;
            default: return '0;
        endcase
    endfunction

    logic [WIDTH-1:0] imm_ext, src_a, src_b;

    always_comb begin
        if (bus.lu_op)       imm_ext = {bus.imm, {(WIDTH-IMM_W){1'b0}}};
        else if (bus.ext_op) imm_ext = {{(WIDTH-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
        else                 imm_ext = {{(WIDTH-IMM_W){1'b0}}, bus.imm};
    end

    assign src_a    = bus.alu_src1 ? {{(WIDTH-SHAMT_W){1'b0}}, bus.shamt} : bus.data_a;
    assign src_b    = bus.alu_src2 ? imm_ext : bus.data_b;
    assign bus.op_a = fwd_sel(bus.fwd_a, src_a, bus.memwb_data, bus.exmem_data);
    assign bus.op_b = fwd_sel(bus.fwd_b, src_b, bus.memwb_data, bus.exmem_data);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   acc_hi;     // mul: running partial product; div: remainder
    logic [WIDTH-1:0] acc_lo;     // mul: multiplier bits; div: dividend -> quotient
    logic [WIDTH-1:0] opnd;       // mul: multiplicand; div: divisor
    logic             is_div, neg_res, neg_rem, b_zero;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             busy_q, done_q;

    // Issue-time magnitudes; the signed ops are the even codes 0 and 2.
    logic             sgn, sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    assign sgn   = ~bus.md_op[0];
    assign sa    = sgn & bus.op_a[WIDTH-1];
    assign sb    = sgn & bus.op_b[WIDTH-1];
    assign mag_a = sa ? -bus.op_a : bus.op_a;
    assign mag_b = sb ? -bus.op_b : bus.op_b;

    // One iteration step.
    logic [WIDTH:0]   mul_pick, div_shift;
    logic             div_ge;
    logic [WIDTH:0]   hi_step;
    logic [WIDTH-1:0] lo_step;

    always_comb begin
        mul_pick  = acc_lo[0] ? acc_hi + {1'b0, opnd} : acc_hi;
        div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd};
        if (is_div) begin
            hi_step = div_ge ? div_shift - {1'b0, opnd} : div_shift;
            lo_step = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            hi_step = {1'b0, mul_pick[WIDTH:1]};
            lo_step = {mul_pick[0], acc_lo[WIDTH-1:1]};
        end
    end

    // Sign fix-up; a zero divisor forces an all-ones quotient regardless of signs.
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s, hi_n, lo_n;

    always_comb begin
        prod   = {acc_hi[WIDTH-1:0], acc_lo};
        prod_s = neg_res ? -prod : prod;
        quo_s  = b_zero ? '1 : (neg_res ? -acc_lo : acc_lo);
        rem_s  = neg_rem ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
        hi_n   = is_div ? rem_s : prod_s[2*WIDTH-1:WIDTH];
        lo_n   = is_div ? quo_s : prod_s[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            opnd    <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            b_zero  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.md_valid) begin
                        if (!bus.md_op[2]) begin
                            is_div  <= bus.md_op[1];
                            neg_res <= sa ^ sb;
                            neg_rem <= sa;
                            b_zero  <= (bus.op_b == '0);
                            acc_hi  <= '0;
                            acc_lo  <= bus.md_op[1] ? mag_a : mag_b;
                            opnd    <= bus.md_op[1] ? mag_b : mag_a;
                            cnt     <= CW'(WIDTH);
                            busy_q  <= 1'b1;
                            state   <= RUN;
                        end else if (bus.md_op == 3'd4) begin
                            hi_q <= bus.op_a;
                        end else if (bus.md_op == 3'd5) begin
                            lo_q <= bus.op_a;
                        end
                    end
                end
                RUN: begin
                    if (cnt == '0) begin
                        done_q <= 1'b1;
                        state  <= FIN;
                    end else begin
                        acc_hi <= hi_step;
                        acc_lo <= lo_step;
                        cnt    <= cnt - CW'(1);
                    end
                end
                FIN: begin
                    hi_q   <= hi_n;
                    lo_q   <= lo_n;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.md_busy   = busy_q;
    assign bus.md_done   = done_q;
    assign bus.stall     = bus.md_valid & busy_q;
    assign bus.md_result = (bus.md_op == 3'd6) ? hi_q :
                           (bus.md_op == 3'd7) ? lo_q : '0;
endmodule

// File: doc/pipeline_ex_muldiv.md
Name: pipeline_ex_muldiv

Overview:
Parametrised EX-stage datapath for the pipelined MIPS core. It performs operand selection (shamt/immediate/register), sign/zero/upper-immediate extension and 3-way forwarding, and presents ALU operands combinationally. It adds an iterative multiply/divide unit with HI/LO registers and a stall handshake to the hazard unit, supporting MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.

Parameters:
WIDTH, 32, datapath width; HI/LO width; iteration count of MUL/DIV
SHAMT_W, 5, shift-amount field width
IMM_W, 16, immediate field width (WIDTH >= 2*IMM_W)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
fwd_a, fwd_b  in  2  forwarding select: 00 stage data, 01 memwb_data, 10 exmem_data, 11 zero
alu_src1  in  1  1: op_a = zero-extended shamt
alu_src2  in  1  1: op_b = extended immediate
ext_op  in  1  1: sign-extend imm, 0: zero-extend
lu_op  in  1  1: op_b = {imm, IMM_W zeros}, overrides ext_op
shamt  in  SHAMT_W  shift amount
imm  in  IMM_W  immediate
data_a, data_b  in  WIDTH  register-file operands
exmem_data, memwb_data  in  WIDTH  forwarded results
op_a, op_b  out  WIDTH  ALU operands (combinational)
md_valid  in  1  MD instruction present in EX
md_op  in  3  0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO,6 MFHI,7 MFLO
md_result  out  WIDTH  HI (op 6) or LO (op 7), else 0; combinational
md_busy  out  1  iteration in progress
md_done  out  1  one-cycle pulse when HI/LO are written by MUL/DIV
stall  out  1  hold IF/ID/EX; request not accepted this cycle
hi, lo  out  WIDTH  architectural HI/LO registers

Behaviour:
- Operand path: src_a = alu_src1 ? zext(shamt) : data_a; src_b = alu_src2 ? ext(imm) : data_b. Forwarding is applied after source selection: op_x = fwd 00 src_x, 01 memwb_data, 10 exmem_data, 11 all-zero. Zero-cycle latency.
- Reset (reset=0, async): state IDLE, hi=lo=0, counter=0, md_busy=0, md_done=0; stall low. Reset mid-operation aborts it; HI/LO are not written.
- FSM IDLE -> RUN -> FIN -> IDLE.
- IDLE: md_valid & op 0-3 -> latch magnitudes (signed ops take |x| and record result signs), counter=WIDTH, go RUN. Op 4/5: HI/LO written from op_a at this edge, stay IDLE. Op 6/7: md_result valid, no stall.
- RUN: one shift-add (mul) or restoring shift-subtract (div) step per cycle; counter decrements; at 0 go FIN. md_busy=1.
- FIN: apply signs (product negated if signs differ; quotient negated if signs differ; remainder takes dividend sign), write hi/lo at the FIN->IDLE edge, md_done=1 in FIN. md_busy=1.
- Latency: issue edge N -> HI/LO valid after edge N+WIDTH+2 (34 cycles at WIDTH=32).
- stall = md_valid & md_busy (any md_op); a stalled request is ignored and re-presented by upstream. Release: stall is low in the first IDLE cycle, when the new HI/LO are visible.
- MUL: {hi,lo} = full 2*WIDTH product. DIV: lo = quotient, hi = remainder.
- Divide by zero: lo = all ones, hi = dividend (unsigned: raw; signed: original signed value). No exception.
- Signed overflow (most-negative / -1): lo = most-negative, hi = 0.
- md_valid=0 or non-MD cycles: no state change.

Test Plan:
- Operands: alu_src2=1, lu_op=1, imm=0x1234 -> op_b=0x12340000; ext_op=1, imm=0x8000 -> op_b=0xFFFF8000; fwd_a=10, exmem_data=0xDEADBEEF -> op_a=0xDEADBEEF; fwd_b=11 -> op_b=0.
- MULT op_a=0xFFFFFFFD (-3), op_b=5 -> md_done after 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULTU 0xFFFFFFFF*2 -> hi=1, lo=0xFFFFFFFE.
- DIVU 100/7 -> lo=14, hi=2; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- DIVU 9/0 -> lo=0xFFFFFFFF, hi=9.
- MULT then MFHI the next cycle -> stall high until the cycle HI is visible, then md_result = new HI; MTLO 0x55 while idle -> lo=0x55 next cycle, stall never high.
- Assert reset at cycle 10 of a DIV -> hi=lo=0, md_busy=0 immediately; next MULT 2*3 -> lo=6.
